// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store initiator for the byte-addressable data memory.
// A request is checked for funct3 legality, alignment and range on acceptance; clean requests
// spend exactly one ACCESS cycle on the memory port, then every request returns one response.
//
// Handshake rule (request and response sides alike): a transfer happens on a rising edge where
// valid and ready are both high; valid, once raised, holds with a stable payload until that edge,
// and ready never depends combinationally on valid.
module load_store_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_SIZE   = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_is_store,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_base,
    input  logic [ADDR_WIDTH-1:0] req_offset,
    input  logic [DATA_WIDTH-1:0] req_store_data,
    input  logic [4:0]            req_rd,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic [4:0]            resp_rd,
    output logic                  resp_is_store,
    output logic [1:0]            resp_fault,
    output logic                  mem_wr_en,
    output logic                  mem_rd_en,
    output logic [3:0]            mem_write_byte_enable,
    output logic [2:0]            mem_load_type,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic [1:0] FAULT_NONE  = 2'b00;
    localparam logic [1:0] FAULT_ALIGN = 2'b01;
    localparam logic [1:0] FAULT_RANGE = 2'b10;
    localparam logic [1:0] FAULT_ILL   = 2'b11;

    // Range limit widened by one bit so addr+size never wraps before the comparison.
    localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH+1)'(MEM_SIZE);

    state_t                r_state;
    state_t                w_next_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_resp_data;
    logic [4:0]            r_rd;
    logic                  r_is_store;
    logic [2:0]            r_funct3;
    logic [1:0]            r_fault;

    logic [ADDR_WIDTH-1:0] w_ea;
    logic [ADDR_WIDTH:0]   w_end;
    logic [2:0]            w_size;
    logic                  w_legal;
    logic                  w_misaligned;
    logic                  w_out_of_range;
    logic [1:0]            w_fault;
    logic                  w_accept;
    logic                  w_access;

    // Effective address wraps naturally at ADDR_WIDTH bits; the end address does not.
    assign w_ea  = req_base + req_offset;
    assign w_end = {1'b0, w_ea} + (ADDR_WIDTH+1)'(w_size);

    // Classify the incoming request: legality, access size, alignment and range.
    always_comb begin
        w_legal = 1'b0;
        w_size  = 3'd4;
        case (req_funct3[1:0])
            2'b00:   w_size = 3'd1;
            2'b01:   w_size = 3'd2;
            default: w_size = 3'd4;
        endcase
        if (req_is_store) begin
            w_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
        end else begin
            w_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                      (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
        end
        w_misaligned   = ((w_size == 3'd2) && w_ea[0]) || ((w_size == 3'd4) && (w_ea[1:0] != 2'b00));
        w_out_of_range = (w_end > MEM_LIMIT);
        // Illegal outranks misaligned, which outranks out-of-range.
        if (!w_legal) begin
            w_fault = FAULT_ILL;
        end else if (w_misaligned) begin
            w_fault = FAULT_ALIGN;
        end else if (w_out_of_range) begin
            w_fault = FAULT_RANGE;
        end else begin
            w_fault = FAULT_NONE;
        end
    end

    // State register; reset returns to IDLE and drops any in-flight response.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and handshake/strobe outputs; reset forces every strobe low in its cycle.
    always_comb begin
        w_next_state = r_state;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        w_access     = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = !rst;
                if (req_valid) begin
                    w_next_state = (w_fault != FAULT_NONE) ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS: begin
                w_access     = !rst;
                w_next_state = S_RESP;
            end
            S_RESP: begin
                resp_valid = !rst;
                if (resp_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    assign w_accept  = req_valid && req_ready;
    assign mem_wr_en = w_access && r_is_store;
    assign mem_rd_en = w_access && !r_is_store;

    // Byte lanes follow the store size; all lanes are off unless a store is on the port.
    always_comb begin
        mem_write_byte_enable = 4'b0000;
        if (mem_wr_en) begin
            case (r_funct3[1:0])
                2'b00:   mem_write_byte_enable = 4'b0001;
                2'b01:   mem_write_byte_enable = 4'b0011;
                default: mem_write_byte_enable = 4'b1111;
            endcase
        end
    end

    // Request capture on acceptance, and load-data capture at the end of ACCESS.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr      <= '0;
            r_wdata     <= '0;
            r_resp_data <= '0;
            r_rd        <= '0;
            r_is_store  <= 1'b0;
            r_funct3    <= 3'b000;
            r_fault     <= FAULT_NONE;
        end else if (w_accept) begin
            r_addr      <= w_ea;
            r_wdata     <= req_store_data;
            r_resp_data <= '0;
            r_rd        <= req_rd;
            r_is_store  <= req_is_store;
            r_funct3    <= req_funct3;
            r_fault     <= w_fault;
        end else if (mem_rd_en) begin
            r_resp_data <= mem_rd_data;
        end
    end

    assign mem_addr      = r_addr;
    assign mem_wr_data   = r_wdata;
    assign mem_load_type = r_funct3;
    assign resp_data     = r_resp_data;
    assign resp_rd       = r_rd;
    assign resp_is_store = r_is_store;
    assign resp_fault    = r_fault;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a 64-byte data memory device, a transaction-level reference
// model with its own byte array, directed scenarios and randomized requests.
module tb_load_store_unit;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MS = 64;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_is_store;
    logic [2:0]    req_funct3;
    logic [AW-1:0] req_base;
    logic [AW-1:0] req_offset;
    logic [DW-1:0] req_store_data;
    logic [4:0]    req_rd;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] resp_data;
    logic [4:0]    resp_rd;
    logic          resp_is_store;
    logic [1:0]    resp_fault;
    logic          mem_wr_en;
    logic          mem_rd_en;
    logic [3:0]    mem_write_byte_enable;
    logic [2:0]    mem_load_type;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wr_data;
    logic [DW-1:0] mem_rd_data;
    logic [1:0]    dbg_state;

    load_store_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_SIZE(MS)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_funct3(req_funct3), .req_base(req_base), .req_offset(req_offset),
        .req_store_data(req_store_data), .req_rd(req_rd),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_rd(resp_rd), .resp_is_store(resp_is_store), .resp_fault(resp_fault),
        .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
        .mem_write_byte_enable(mem_write_byte_enable), .mem_load_type(mem_load_type),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
        .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- memory device ----------------
    logic [7:0] dmem [0:MS-1];
    bit         dmem_init_done;
    logic [7:0] d0, d1, d2, d3;

    always_comb begin
        d0 = dmem[mem_addr[5:0]];
        d1 = dmem[mem_addr[5:0] + 6'd1];
        d2 = dmem[mem_addr[5:0] + 6'd2];
        d3 = dmem[mem_addr[5:0] + 6'd3];
        mem_rd_data = 32'h0;
        if (mem_rd_en) begin
            case (mem_load_type)
                3'b000:  mem_rd_data = {{24{d0[7]}}, d0};
                3'b001:  mem_rd_data = {{16{d1[7]}}, d1, d0};
                3'b010:  mem_rd_data = {d3, d2, d1, d0};
                3'b100:  mem_rd_data = {24'h0, d0};
                3'b101:  mem_rd_data = {16'h0, d1, d0};
                default: mem_rd_data = 32'h0;
            endcase
        end
    end

    always @(posedge clk) begin
        if (!dmem_init_done) begin
            for (int i = 0; i < MS; i++) dmem[i] = 8'(i * 37 + 5);
            dmem_init_done = 1'b1;
        end else if (mem_wr_en) begin
            for (int i = 0; i < 4; i++)
                if (mem_write_byte_enable[i]) dmem[mem_addr[5:0] + 6'(i)] = mem_wr_data[8*i +: 8];
        end
    end

    // ---------------- reference model ----------------
    logic [7:0] ref_mem [0:MS-1];
    bit         ref_init_done;

    function automatic logic [1:0] ref_fault(input logic st, input logic [2:0] f3, input logic [31:0] a);
        int unsigned       sz;
        longint unsigned   last;
        if (st ? (f3 > 3'd2) : !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5))
            return 2'b11;
        sz = 1 << f3[1:0];
        if ((a % sz) != 0) return 2'b01;
        last = a;
        last = last + sz;
        if (last > MS) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        logic [7:0] b0, b1, b2, b3;
        b0 = ref_mem[a % MS];
        b1 = ref_mem[(a + 1) % MS];
        b2 = ref_mem[(a + 2) % MS];
        b3 = ref_mem[(a + 3) % MS];
        case (f3)
            3'd0:    return (b0 >= 8'h80) ? 32'(b0) - 32'h100 : 32'(b0);
            3'd1:    return ({b1, b0} >= 16'h8000) ? 32'({b1, b0}) - 32'h10000 : 32'({b1, b0});
            3'd2:    return {b3, b2, b1, b0};
            3'd4:    return 32'(b0);
            3'd5:    return 32'({b1, b0});
            default: return 32'h0;
        endcase
    endfunction

    int          n_vec;
    int          n_err;
    int          cyc;
    logic        m_busy;
    int          m_acc;
    int          m_resp;
    int          m_sz;
    logic        m_st;
    logic [2:0]  m_f3;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_data;
    logic [4:0]  m_rd;
    logic [1:0]  m_fault;
    logic        m_post_rst;
    logic        e_ready, e_acc, e_rv;
    logic [3:0]  e_be;

    string       pin_name_q[$];
    logic [31:0] pin_got_q[$];
    logic [31:0] pin_exp_q[$];

    task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %h expected %h", n, cyc, got, exp);
        end
    endtask

    // Model update at each edge, then compare the DUT outputs shortly after the edge.
    always @(posedge clk) begin
        if (!ref_init_done) begin
            for (int i = 0; i < MS; i++) ref_mem[i] = 8'(i * 37 + 5);
            ref_init_done = 1'b1;
            m_busy = 1'b0;
            m_acc  = -1;
            m_resp = -1;
        end
        m_post_rst = rst;
        if (rst) begin
            m_busy = 1'b0;
        end else if (m_busy) begin
            if (cyc == m_acc) begin
                if (m_st) begin
                    for (int i = 0; i < m_sz; i++) ref_mem[(m_addr + 32'(i)) % MS] = m_wdata[8*i +: 8];
                end else begin
                    m_data = ref_load(m_f3, m_addr);
                end
            end
            if (cyc >= m_resp && resp_ready) m_busy = 1'b0;
        end else if (req_valid) begin
            m_addr  = req_base + req_offset;
            m_st    = req_is_store;
            m_f3    = req_funct3;
            m_rd    = req_rd;
            m_wdata = req_store_data;
            m_fault = ref_fault(req_is_store, req_funct3, m_addr);
            m_sz    = 1 << req_funct3[1:0];
            m_data  = 32'h0;
            m_busy  = 1'b1;
            m_acc   = (m_fault == 2'b00) ? cyc + 1 : -1;
            m_resp  = (m_fault == 2'b00) ? cyc + 2 : cyc + 1;
        end
        cyc++;
        #2;
        e_ready = !m_busy && !rst;
        e_acc   = m_busy && (cyc == m_acc) && !rst;
        e_rv    = m_busy && (cyc >= m_resp) && !rst;
        e_be    = (e_acc && m_st) ? 4'((1 << m_sz) - 1) : 4'b0000;
        chk("ctrl{ready,rvalid,wr,rd,be}",
            64'({req_ready, resp_valid, mem_wr_en, mem_rd_en, mem_write_byte_enable}),
            64'({e_ready, e_rv, e_acc && m_st, e_acc && !m_st, e_be}));
        if (e_acc) begin
            chk("mem_addr", 64'(mem_addr), 64'(m_addr));
            chk("mem_load_type", 64'(mem_load_type), 64'(m_f3));
            if (m_st) chk("mem_wr_data", 64'(mem_wr_data), 64'(m_wdata));
        end
        if (e_rv) begin
            chk("resp{rd,is_store,fault}", 64'({resp_rd, resp_is_store, resp_fault}), 64'({m_rd, m_st, m_fault}));
            chk("resp_data", 64'(resp_data), 64'(m_data));
        end
        if (m_post_rst) begin
            chk("reset_regs", 64'({resp_data, resp_rd, resp_is_store, resp_fault, mem_load_type}), 64'(0));
            chk("reset_mem_regs", {mem_addr, mem_wr_data}, 64'(0));
        end
        while (pin_name_q.size() > 0)
            chk(pin_name_q.pop_front(), 64'(pin_got_q.pop_front()), 64'(pin_exp_q.pop_front()));
    end

    // ---------------- driver ----------------
    task automatic pin(input string n, input logic [31:0] got, input logic [31:0] exp);
        pin_name_q.push_back(n);
        pin_got_q.push_back(got);
        pin_exp_q.push_back(exp);
    endtask

    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] base,
                          input logic [31:0] off, input logic [31:0] wd, input int hold,
                          output logic [31:0] got_d, output logic [1:0] got_f, output int lat);
        int hc;
        got_d = 32'hFFFF_FFFF;
        got_f = 2'b11;
        lat   = -1;
        hc    = 0;
        @(negedge clk);
        req_valid      = 1'b1;
        req_is_store   = st;
        req_funct3     = f3;
        req_base       = base;
        req_offset     = off;
        req_store_data = wd;
        req_rd         = 5'($urandom_range(0, 31));
        resp_ready     = (hold == 0);
        for (int n = 0; n < 20 && !req_ready; n++) @(negedge clk);
        if (!req_ready) begin
            pin("accept_timeout", 32'h0, 32'h1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid      = 1'b0;
        req_is_store   = 1'($urandom_range(0, 1));
        req_funct3     = 3'($urandom_range(0, 7));
        req_base       = $urandom;
        req_offset     = $urandom;
        req_store_data = $urandom;
        for (int n = 0; n < 20; n++) begin
            if (resp_valid) begin
                if (lat < 0) lat = n;
                if (hc >= hold) begin
                    resp_ready = 1'b1;
                    got_d      = resp_data;
                    got_f      = resp_fault;
                    @(posedge clk);
                    return;
                end
                pin("ready_while_busy", 32'(req_ready), 32'h0);
                hc++;
            end
            @(negedge clk);
        end
        pin("resp_timeout", 32'h0, 32'h1);
    endtask

    logic [31:0] gd;
    logic [1:0]  gf;
    int          gl;
    logic        r_st;
    logic [2:0]  r_f3;

    initial begin
        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        rst = 1'b1;
        req_valid = 1'b0;
        req_is_store = 1'b0;
        req_funct3 = 3'b000;
        req_base = '0;
        req_offset = '0;
        req_store_data = '0;
        req_rd = '0;
        resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1 pin("ready_after_reset", 32'(req_ready), 32'h1);

        // store word then read it back
        do_req(1'b1, 3'b010, 32'h10, 32'h4, 32'hDEADBEEF, 0, gd, gf, gl);
        pin("sw_fault", 32'(gf), 32'h0);
        pin("sw_data", gd, 32'h0);
        do_req(1'b0, 3'b010, 32'h14, 32'h0, 32'h0, 0, gd, gf, gl);
        pin("lw_data", gd, 32'hDEADBEEF);
        pin("lw_latency", 32'(gl), 32'h1);

        // byte store, signed and unsigned byte loads
        do_req(1'b1, 3'b000, 32'h20, 32'h1, 32'h0000_0080, 0, gd, gf, gl);
        do_req(1'b0, 3'b000, 32'h21, 32'h0, 32'h0, 0, gd, gf, gl);
        pin("lb_data", gd, 32'hFFFF_FF80);
        do_req(1'b0, 3'b100, 32'h21, 32'h0, 32'h0, 0, gd, gf, gl);
        pin("lbu_data", gd, 32'h0000_0080);

        // halfword store, halfword loads and the upper byte on its own
        do_req(1'b1, 3'b001, 32'h22, 32'h0, 32'h1234_ABCD, 0, gd, gf, gl);
        do_req(1'b0, 3'b001, 32'h22, 32'h0, 32'h0, 0, gd, gf, gl);
        pin("lh_data", gd, 32'hFFFF_ABCD);
        do_req(1'b0, 3'b101, 32'h22, 32'h0, 32'h0, 0, gd, gf, gl);
        pin("lhu_data", gd, 32'h0000_ABCD);
        do_req(1'b0, 3'b100, 32'h23, 32'h0, 32'h0, 0, gd, gf, gl);
        pin("lbu_hi_byte", gd, 32'h0000_00AB);

        // faults
        do_req(1'b0, 3'b010, 32'h3E, 32'h0, 32'h0, 0, gd, gf, gl);
        pin("lw_3e_fault", 32'(gf), 32'h1);
        pin("lw_3e_data", gd, 32'h0);
        pin("fault_latency", 32'(gl), 32'h0);
        do_req(1'b0, 3'b010, 32'h40, 32'h0, 32'h0, 0, gd, gf, gl);
        pin("lw_40_fault", 32'(gf), 32'h2);
        do_req(1'b1, 3'b010, 32'h3C, 32'h0, 32'h5555_6666, 0, gd, gf, gl);
        pin("sw_3c_fault", 32'(gf), 32'h0);
        do_req(1'b0, 3'b001, 32'h3F, 32'h0, 32'h0, 0, gd, gf, gl);
        pin("lh_3f_fault", 32'(gf), 32'h1);
        do_req(1'b1, 3'b100, 32'h3F, 32'h0, 32'h0, 0, gd, gf, gl);
        pin("st_f3_100_fault", 32'(gf), 32'h3);
        do_req(1'b0, 3'b010, 32'hFFFF_FFFC, 32'h8, 32'h0, 0, gd, gf, gl);
        pin("wrap_addr_fault", 32'(gf), 32'h0);
        do_req(1'b0, 3'b010, 32'h20, 32'hFFFF_FFF4, 32'h0, 0, gd, gf, gl);
        pin("neg_offset_lw", gd, 32'hDEADBEEF);

        // response back-pressure
        do_req(1'b0, 3'b010, 32'h14, 32'h0, 32'h0, 5, gd, gf, gl);
        pin("held_lw_data", gd, 32'hDEADBEEF);

        // reset during the ACCESS cycle of a store suppresses the write
        do_req(1'b1, 3'b010, 32'h8, 32'h0, 32'h1122_3344, 0, gd, gf, gl);
        @(negedge clk);
        req_valid      = 1'b1;
        req_is_store   = 1'b1;
        req_funct3     = 3'b010;
        req_base       = 32'h8;
        req_offset     = 32'h0;
        req_store_data = 32'hAAAA_AAAA;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst       = 1'b1;
        #1 pin("abort_wr_en", 32'(mem_wr_en), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1 pin("ready_after_abort", 32'(req_ready), 32'h1);
        do_req(1'b0, 3'b010, 32'h8, 32'h0, 32'h0, 0, gd, gf, gl);
        pin("lw_after_abort", gd, 32'h1122_3344);

        // randomized traffic
        for (int t = 0; t < 300; t++) begin
            r_st = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) < 8) begin
                if (r_st) begin
                    r_f3 = 3'($urandom_range(0, 2));
                end else begin
                    case ($urandom_range(0, 4))
                        0: r_f3 = 3'd0;
                        1: r_f3 = 3'd1;
                        2: r_f3 = 3'd2;
                        3: r_f3 = 3'd4;
                        default: r_f3 = 3'd5;
                    endcase
                end
            end else begin
                r_f3 = 3'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 9) == 0) begin
                do_req(r_st, r_f3, $urandom, $urandom, $urandom, $urandom_range(0, 3), gd, gf, gl);
            end else begin
                do_req(r_st, r_f3, 32'($urandom_range(0, 70)), 32'($urandom_range(0, 15)) - 32'd8,
                       $urandom, $urandom_range(0, 3), gd, gf, gl);
            end
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
